// File: rtl/uart_frame_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser_pkg
//  Brief    : Shared state encoding, default header bytes and timeout sizing
//             for the UART command-frame parser.
//  Revision : 1.0
// ============================================================================
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_H1  = 3'd1,
        ST_GET_LEN  = 3'd2,
        ST_GET_PAY  = 3'd3,
        ST_GET_CSUM = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    localparam logic [7:0] c_hdr0 = 8'h55;
    localparam logic [7:0] c_hdr1 = 8'hAA;

    function automatic int unsigned tmo_cycles(input int unsigned clk_freq,
                                               input int unsigned timeout_us);
        return (clk_freq / 32'd1_000_000) * timeout_us;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser_if
//  Brief    : Byte-in / payload-stream-out bundle of the frame parser.
//             UART_PARSER_STATS_EN adds the ok_cnt / err_cnt statistics.
//  Revision : 1.0
// ============================================================================
interface uart_frame_parser_if;
    logic       uart_done;
    logic [7:0] uart_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;
`ifdef UART_PARSER_STATS_EN
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    modport master (
        input  uart_done, uart_data, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, busy,
        output ok_cnt, err_cnt
    );
    modport slave (
        output uart_done, uart_data, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, busy,
        input  ok_cnt, err_cnt
    );
`else
    modport master (
        input  uart_done, uart_data, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, busy
    );
    modport slave (
        output uart_done, uart_data, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_buf
//  Brief    : DEPTH x 8 simple dual-port payload store, synchronous write,
//             combinational read.
//  Revision : 1.0
// ============================================================================
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [7:0]    wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [7:0]    rd_data
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser
//  Brief    : Assembles HDR0 HDR1 LEN payload CSUM frames from received UART
//             bytes, verifies the checksum and streams the payload out.
//             Optional statistics counters: UART_PARSER_STATS_EN.
//  Revision : 1.0
// ============================================================================
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [7:0]  HDR0       = c_hdr0,
    parameter logic [7:0]  HDR1       = c_hdr1
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst,
    uart_frame_parser_if.master bus
);
    localparam int unsigned c_tmo_cyc = tmo_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int unsigned c_tmo_w   = $clog2(c_tmo_cyc + 1);
    localparam int unsigned c_aw      = $clog2(MAX_LEN);
    localparam logic [7:0]  c_max_len = 8'(MAX_LEN);
    // Counter is cleared in the strobe cycle, so expiry at TMO-2 puts the
    // frame_err pulse exactly TMO cycles after the last byte's strobe.
    localparam logic [c_tmo_w-1:0] c_tmo_last =
        (c_tmo_cyc >= 2) ? c_tmo_w'(c_tmo_cyc - 2) : '0;

    state_t               r_state;
    state_t               w_state_nx;
    logic [7:0]           r_len;
    logic [7:0]           r_csum;
    logic [7:0]           r_idx;
    logic [c_tmo_w-1:0]   r_tmo;
    logic                 r_frame_ok;
    logic                 r_frame_err;
    logic                 w_ok;
    logic                 w_err;
    logic                 w_store_len;
    logic                 w_wr_en;
    logic                 w_rd_adv;
    logic                 w_drop;
    logic                 w_tmo;
    logic                 w_last;
    logic                 w_valid;
    logic [7:0]           w_rd_data;

    assign w_tmo   = (r_tmo == c_tmo_last);
    assign w_last  = (r_idx == r_len - 8'd1);
    assign w_valid = (r_state == ST_DRAIN);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_store_len = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_adv    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.uart_done && bus.uart_data == HDR0) begin
                    w_state_nx = ST_WAIT_H1;
                end
            end
            ST_WAIT_H1: begin
                if (bus.uart_done) begin
                    if (bus.uart_data == HDR1) begin
                        w_state_nx = ST_GET_LEN;
                    end else if (bus.uart_data != HDR0) begin
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GET_LEN: begin
                if (bus.uart_done) begin
                    if (bus.uart_data == 8'd0 || bus.uart_data > c_max_len) begin
                        w_err      = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_store_len = 1'b1;
                        w_state_nx  = ST_GET_PAY;
                    end
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GET_PAY: begin
                if (bus.uart_done) begin
                    w_wr_en = 1'b1;
                    if (w_last) begin
                        w_state_nx = ST_GET_CSUM;
                    end
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_GET_CSUM: begin
                if (bus.uart_done) begin
                    if (bus.uart_data == r_csum) begin
                        w_ok       = 1'b1;
                        w_state_nx = ST_DRAIN;
                    end else begin
                        w_err      = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_tmo) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_drop   = bus.uart_done;
                w_rd_adv = bus.out_ready;
                if (bus.out_ready && w_last) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // r_idx is the write index while collecting and the read index in DRAIN.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_len       <= 8'd0;
            r_csum      <= 8'd0;
            r_idx       <= 8'd0;
            r_tmo       <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            if (w_store_len) begin
                r_len  <= bus.uart_data;
                r_csum <= bus.uart_data;
                r_idx  <= 8'd0;
            end else if (w_wr_en) begin
                r_csum <= r_csum + bus.uart_data;
                r_idx  <= r_idx + 8'd1;
            end else if (w_ok) begin
                r_idx  <= 8'd0;
            end else if (w_rd_adv) begin
                r_idx  <= r_idx + 8'd1;
            end
            if (w_state_nx == ST_IDLE || w_state_nx == ST_DRAIN || bus.uart_done) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_aw)
    ) u_buf (
        .clk     (sys_clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_idx[c_aw-1:0]),
        .wr_data (bus.uart_data),
        .rd_addr (r_idx[c_aw-1:0]),
        .rd_data (w_rd_data)
    );

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_rd_data : 8'h00;
    assign bus.out_last  = w_valid & w_last;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != ST_IDLE);

`ifdef UART_PARSER_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;

    // Dropped DRAIN bytes count as errors; they never coincide with w_err.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ok_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_ok && r_ok_cnt != 16'hFFFF) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if ((w_err || w_drop) && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign bus.ok_cnt  = r_ok_cnt;
    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_frame_parser
//  Brief    : Directed self-checking bench for uart_frame_parser.
//  Revision : 1.0
// ============================================================================
module tb_uart_frame_parser;
    localparam int unsigned c_clk_freq   = 1_000_000;
    localparam int unsigned c_timeout_us = 200;
    localparam int          c_tmo        = 200;
    localparam int          c_gap        = 10;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_ok = 0;
    int   n_err = 0;
    int   n_both = 0;
    int   ok_cyc = 0;
    int   err_cyc = 0;
    int   done_cyc = 0;
    logic [7:0] q_data [$];
    logic       q_last [$];
    int         q_cyc  [$];

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .CLK_FREQ   (c_clk_freq),
        .TIMEOUT_US (c_timeout_us),
        .MAX_LEN    (16),
        .HDR0       (8'h55),
        .HDR1       (8'hAA)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (bus.uart_done) done_cyc = cyc;
        if (bus.frame_ok) begin n_ok++; ok_cyc = cyc; end
        if (bus.frame_err) begin n_err++; err_cyc = cyc; end
        if (bus.frame_ok && bus.frame_err) n_both++;
        if (bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        bus.uart_done = 1'b1;
        bus.uart_data = b;
        @(posedge sys_clk); #1;
        bus.uart_done = 1'b0;
        repeat (c_gap - 2) @(posedge sys_clk);
    endtask

    task automatic send_good();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h69);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int i = 0;
        while (bus.busy && i < lim) begin
            @(negedge sys_clk);
            i++;
        end
        chk(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    // Expected payload 11 22 33, last on the third; optionally on cycles first..first+2.
    task automatic check_stream(input string tag, input int qb, input int first);
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        chk({tag, "_count"}, q_data.size() - qb, 3);
        if (q_data.size() - qb == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s_data%0d", tag, k), {24'd0, q_data[qb+k]}, {24'd0, exp[k]});
                chk($sformatf("%s_last%0d", tag, k), {31'd0, q_last[qb+k]}, (k == 2) ? 32'd1 : 32'd0);
                if (first >= 0)
                    chk($sformatf("%s_cyc%0d", tag, k), q_cyc[qb+k], first + k);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, bus.out_data},  32'd0);
        chk({tag, "_last"},  {31'd0, bus.out_last},  32'd0);
        chk({tag, "_ok"},    {31'd0, bus.frame_ok},  32'd0);
        chk({tag, "_err"},   {31'd0, bus.frame_err}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.busy},      32'd0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge sys_clk); #3;
        sys_rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    initial begin
        int ok0, err0, qb, d, bad;
        sys_rst       = 1'b1;
        bus.uart_done = 1'b0;
        bus.uart_data = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge sys_clk);
        check_outputs_zero("reset");
`ifdef UART_PARSER_STATS_EN
        chk("reset_ok_cnt",  {16'd0, bus.ok_cnt},  32'd0);
        chk("reset_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
`endif
        release_reset();

        // Good frame, out_ready high
        ok0 = n_ok; err0 = n_err; qb = q_data.size();
        send_good();
        d = done_cyc;
        wait_idle("good_idle", 20);
        chk("good_ok_pulses", n_ok - ok0, 1);
        chk("good_err_pulses", n_err - err0, 0);
        chk("good_ok_latency", ok_cyc - d, 1);
        check_stream("good", qb, d + 1);

        // Bad checksum
        ok0 = n_ok; err0 = n_err; qb = q_data.size();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h68);
        d = done_cyc;
        chk("badcs_err_pulses", n_err - err0, 1);
        chk("badcs_err_latency", err_cyc - d, 1);
        chk("badcs_ok_pulses", n_ok - ok0, 0);
        chk("badcs_no_output", q_data.size() - qb, 0);
        chk("badcs_busy", {31'd0, bus.busy}, 32'd0);

        // Illegal lengths 0 and 17
        err0 = n_err;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
        d = done_cyc;
        chk("len0_err_pulses", n_err - err0, 1);
        chk("len0_err_latency", err_cyc - d, 1);
        chk("len0_busy", {31'd0, bus.busy}, 32'd0);
        err0 = n_err;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
        d = done_cyc;
        chk("len17_err_pulses", n_err - err0, 1);
        chk("len17_err_latency", err_cyc - d, 1);
        chk("len17_busy", {31'd0, bus.busy}, 32'd0);

        // Header resync then timeout
        err0 = n_err;
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h02); send_byte(8'h01);
        d = done_cyc;
        chk("tmo_no_early_err", n_err - err0, 0);
        chk("tmo_busy_before", {31'd0, bus.busy}, 32'd1);
        repeat (c_tmo + 20) @(negedge sys_clk);
        chk("tmo_err_pulses", n_err - err0, 1);
        chk("tmo_err_latency", err_cyc - d, c_tmo);
        chk("tmo_busy_after", {31'd0, bus.busy}, 32'd0);

        // Back-pressure with a byte injected during DRAIN
        reset_mid_cycle();
        release_reset();
        ok0 = n_ok; err0 = n_err; qb = q_data.size();
        bus.out_ready = 1'b0;
        send_good();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge sys_clk); #1;
            bus.uart_done = (i == 20);
            bus.uart_data = 8'h55;
            @(negedge sys_clk);
            if (!(bus.out_valid && bus.out_data == 8'h11 && !bus.out_last)) bad++;
        end
        bus.uart_done = 1'b0;
        chk("bp_stall_hold_errors", bad, 0);
        @(posedge sys_clk); #1;
        bus.out_ready = 1'b1;
        wait_idle("bp_idle", 20);
        repeat (3) @(negedge sys_clk);
        chk("bp_drop_not_parsed", {31'd0, bus.busy}, 32'd0);
        chk("bp_ok_pulses", n_ok - ok0, 1);
        chk("bp_err_pulses", n_err - err0, 0);
        check_stream("bp", qb, -1);
`ifdef UART_PARSER_STATS_EN
        chk("bp_ok_cnt",  {16'd0, bus.ok_cnt},  32'd1);
        chk("bp_err_cnt", {16'd0, bus.err_cnt}, 32'd1);
`endif

        // Reset mid-payload, then a clean frame
        err0 = n_err;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        reset_mid_cycle();
        check_outputs_zero("rstpay");
        release_reset();
        repeat (3) @(negedge sys_clk);
        chk("rstpay_no_err", n_err - err0, 0);
        qb = q_data.size();
        send_good();
        d = done_cyc;
        wait_idle("rstpay_idle", 20);
        check_stream("rstpay_good", qb, d + 1);

        // Reset mid-drain
        bus.out_ready = 1'b0;
        send_good();
        chk("rstdrain_valid_before", {31'd0, bus.out_valid}, 32'd1);
        reset_mid_cycle();
        chk("rstdrain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstdrain_busy", {31'd0, bus.busy}, 32'd0);
        release_reset();
        bus.out_ready = 1'b1;

        chk("ok_err_exclusive", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
